// File: rtl/reg_arith_exec_seq.sv
// RV32I register-register execute sequencer.
// Single-cycle ALU ops, iterative shifter, held valid/ready result.
package reg_arith_pkg;
  typedef enum logic [3:0] {
    rak_invalid,
    rak_add,
    rak_sub,
    rak_sll,
    rak_slt,
    rak_sltu,
    rak_xor,
    rak_srl,
    rak_sra,
    rak_or,
    rak_and
  } reg_arith_kind_t;
endpackage

module reg_arith_exec_seq
  import reg_arith_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_arith_kind_t in_kind,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_RESP
  } state_t;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [5:0]      rem_q, rem_d;
  reg_arith_kind_t kind_q, kind_d;
  logic [4:0]      rd_q, rd_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic            is_shift;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu;
  logic [5:0]      step;
  logic [XLEN-1:0] shifted;

  assign in_ready = !flush &&
    (state_q == S_IDLE || (state_q == S_RESP && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = in_rs2[4:0];
  assign is_shift = in_kind == rak_sll ||
                    in_kind == rak_srl ||
                    in_kind == rak_sra;

  always_comb begin
    alu = '0;
    unique case (1'b1)
      in_kind == rak_add:  alu = in_rs1 + in_rs2;
      in_kind == rak_sub:  alu = in_rs1 - in_rs2;
      in_kind == rak_slt:
        alu = {{(XLEN-1){1'b0}},
               $signed(in_rs1) < $signed(in_rs2)};
      in_kind == rak_sltu:
        alu = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
      in_kind == rak_xor:  alu = in_rs1 ^ in_rs2;
      in_kind == rak_or:   alu = in_rs1 | in_rs2;
      in_kind == rak_and:  alu = in_rs1 & in_rs2;
      // zero-amount shifts bypass the shifter
      is_shift:            alu = in_rs1;
      default:             alu = '0;
    endcase
  end

  always_comb begin
    step    = (rem_q < STEP) ? rem_q : STEP;
    shifted = res_q;
    unique case (1'b1)
      kind_q == rak_sll: shifted = res_q << step;
      kind_q == rak_srl: shifted = res_q >> step;
      default:
        shifted = XLEN'($signed(res_q) >>> step);
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rem_d   = rem_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = S_IDLE;
      res_d   = '0;
      rem_d   = '0;
      rd_d    = '0;
      ill_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          res_d = shifted;
          rem_d = rem_q - step;
          if (rem_q == step) state_d = S_RESP;
        end
        S_RESP: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        rd_d   = in_rd;
        ill_d  = in_kind == rak_invalid;
        kind_d = in_kind;
        if (is_shift && shamt != 5'd0) begin
          state_d = S_SHIFT;
          res_d   = in_rs1;
          rem_d   = {1'b0, shamt};
        end else begin
          state_d = S_RESP;
          res_d   = alu;
          rem_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      kind_q  <= rak_invalid;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = state_q == S_RESP;
  assign out_result  = res_q;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;
  assign busy        = state_q != S_IDLE;

endmodule
